// File: rtl/cmd_scheduler_if.sv
// rtl/cmd_scheduler_if.sv - requester, physical-layer and status signals of the command scheduler
// master is the scheduler side; slave is the requesters plus physical layer.
interface cmd_scheduler_if;
    logic         req_sw;
    logic [37:0]  cmd_sw;
    logic         req_auto;
    logic [31:0]  arg_auto;
    logic         phy_strobe;
    logic [37:0]  phy_cmd;
    logic         phy_resp_valid;
    logic [135:0] phy_response;
    logic         phy_no_response;
    logic         phy_ack;
    logic         phy_idle;
    logic         gnt_sw;
    logic         gnt_auto;
    logic         done_sw;
    logic         done_auto;
    logic [135:0] resp;
    logic         cmd_timeout;
    logic [1:0]   retry_cnt;

    modport master (
        input  req_sw, cmd_sw, req_auto, arg_auto,
        input  phy_resp_valid, phy_response, phy_no_response,
        output phy_strobe, phy_cmd, phy_ack, phy_idle,
        output gnt_sw, gnt_auto, done_sw, done_auto,
        output resp, cmd_timeout, retry_cnt
    );

    modport slave (
        output req_sw, cmd_sw, req_auto, arg_auto,
        output phy_resp_valid, phy_response, phy_no_response,
        input  phy_strobe, phy_cmd, phy_ack, phy_idle,
        input  gnt_sw, gnt_auto, done_sw, done_auto,
        input  resp, cmd_timeout, retry_cnt
    );
endinterface

// File: rtl/cmd_scheduler.sv
// rtl/cmd_scheduler.sv - arbitrates auto-stop vs software commands and drives one command at a time with timeout/retry
// Auto-stop (CMD12) wins arbitration; a timed-out command is re-issued up to MAX_RETRY times.
module cmd_scheduler #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_RETRY      = 2
) (
    input logic             sd_clock,
    input logic             reset,
    cmd_scheduler_if.master bus
);

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_ISSUE = 6'b000010,
        S_WAIT  = 6'b000100,
        S_ACK   = 6'b001000,
        S_ABORT = 6'b010000,
        S_DONE  = 6'b100000
    } state_t;

    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);
    localparam logic [5:0] CMD12_IDX = 6'd12;

    state_t         state_q, state_d;
    logic           gnt_sw_q, gnt_sw_d;
    logic           gnt_auto_q, gnt_auto_d;
    logic [37:0]    cmd_q, cmd_d;
    logic [135:0]   resp_q, resp_d;
    logic [7:0]     tmo_cnt_q, tmo_cnt_d;
    logic [1:0]     retry_q, retry_d;
    logic           timeout_q, timeout_d;
    logic           no_resp_q, no_resp_d;

    logic           strobe, ack, idle_pulse, done_sw, done_auto;

    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            gnt_sw_q   <= 1'b0;
            gnt_auto_q <= 1'b0;
            cmd_q      <= '0;
            resp_q     <= '0;
            tmo_cnt_q  <= '0;
            retry_q    <= '0;
            timeout_q  <= 1'b0;
            no_resp_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_sw_q   <= gnt_sw_d;
            gnt_auto_q <= gnt_auto_d;
            cmd_q      <= cmd_d;
            resp_q     <= resp_d;
            tmo_cnt_q  <= tmo_cnt_d;
            retry_q    <= retry_d;
            timeout_q  <= timeout_d;
            no_resp_q  <= no_resp_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_sw_d   = gnt_sw_q;
        gnt_auto_d = gnt_auto_q;
        cmd_d      = cmd_q;
        resp_d     = resp_q;
        tmo_cnt_d  = tmo_cnt_q;
        retry_d    = retry_q;
        timeout_d  = timeout_q;
        no_resp_d  = no_resp_q;
        strobe     = 1'b0;
        ack        = 1'b0;
        idle_pulse = 1'b0;
        done_sw    = 1'b0;
        done_auto  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_auto || bus.req_sw) begin
                    gnt_auto_d = bus.req_auto;
                    gnt_sw_d   = !bus.req_auto;
                    cmd_d      = bus.req_auto ? {CMD12_IDX, bus.arg_auto} : bus.cmd_sw;
                    tmo_cnt_d  = '0;
                    retry_d    = '0;
                    timeout_d  = 1'b0;
                    no_resp_d  = 1'b0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                strobe    = 1'b1;
                tmo_cnt_d = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + 8'd1;
                // A response on the last counted cycle still beats the timeout.
                if (bus.phy_resp_valid) begin
                    no_resp_d = bus.phy_no_response;
                    if (!bus.phy_no_response) begin
                        resp_d = bus.phy_response;
                    end
                    state_d = S_ACK;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = S_ABORT;
                end
            end
            S_ACK: begin
                ack       = 1'b1;
                no_resp_d = 1'b0;
                state_d   = no_resp_q ? S_ABORT : S_DONE;
            end
            S_ABORT: begin
                idle_pulse = 1'b1;
                if (retry_q < RETRY_MAX) begin
                    retry_d   = retry_q + 2'd1;
                    tmo_cnt_d = '0;
                    state_d   = S_ISSUE;
                end else begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                done_sw    = gnt_sw_q;
                done_auto  = gnt_auto_q;
                gnt_sw_d   = 1'b0;
                gnt_auto_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                gnt_sw_d   = 1'b0;
                gnt_auto_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    assign bus.phy_strobe  = strobe;
    assign bus.phy_cmd     = cmd_q;
    assign bus.phy_ack     = ack;
    assign bus.phy_idle    = idle_pulse;
    assign bus.gnt_sw      = gnt_sw_q;
    assign bus.gnt_auto    = gnt_auto_q;
    assign bus.done_sw     = done_sw;
    assign bus.done_auto   = done_auto;
    assign bus.resp        = resp_q;
    assign bus.cmd_timeout = timeout_q;
    assign bus.retry_cnt   = retry_q;

endmodule

// File: tb/tb_cmd_scheduler.sv
// tb/tb_cmd_scheduler.sv - randomized self-checking bench for cmd_scheduler against an attempt-level model
module tb_cmd_scheduler;
    localparam int T  = 64;
    localparam int MR = 2;
    localparam int K_OK  = 0;
    localparam int K_SIL = 1;
    localparam int K_NR  = 2;

    typedef struct {
        int           kind;
        int           d;
        logic [135:0] data;
    } att_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmd_scheduler_if bus();

    cmd_scheduler #(.TIMEOUT_CYCLES(T), .MAX_RETRY(MR)) dut (
        .sd_clock (clk),
        .reset    (rst_n),
        .bus      (bus)
    );

    int           n_tests = 0;
    int           n_fail  = 0;
    att_t         plan_q[$];
    logic [135:0] last_resp = '0;

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [135:0] rnd136();
        return {8'($urandom()), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Attempt-level expectation: stop at first good response, each failure costs a fixed cycle span.
    function automatic void model(input att_t p[3], input logic [135:0] prev,
                                  output int n_att, output int idles, output int acks,
                                  output int retry, output int tmo, output int lat,
                                  output logic [135:0] r);
        bit ok = 0;
        int fails = 0;
        n_att = 0; idles = 0; acks = 0; lat = 0; r = prev;
        for (int i = 0; i <= MR && !ok; i++) begin
            n_att++;
            if (p[i].kind == K_OK) begin
                ok = 1; acks++; lat += p[i].d + 2; r = p[i].data;
            end else begin
                fails++; idles++;
                if (p[i].kind == K_NR) begin
                    acks++; lat += p[i].d + 3;
                end else begin
                    lat += T + 2;
                end
            end
        end
        retry = ok ? fails : MR;
        tmo   = ok ? 0 : 1;
    endfunction

    // Physical-layer responder: one plan entry per command strobe.
    initial begin
        att_t a;
        int   g;
        bus.phy_resp_valid  = 1'b0;
        bus.phy_response    = '0;
        bus.phy_no_response = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.phy_strobe) begin
                if (plan_q.size() > 0) a = plan_q.pop_front();
                else a = '{K_SIL, 1, '0};
                if (a.kind != K_SIL) begin
                    repeat (a.d) @(negedge clk);
                    bus.phy_resp_valid  = 1'b1;
                    bus.phy_no_response = (a.kind == K_NR);
                    bus.phy_response    = a.data;
                    g = 0;
                    do begin
                        @(negedge clk);
                        g++;
                    end while (!bus.phy_ack && rst_n && g < 20);
                    bus.phy_resp_valid  = 1'b0;
                    bus.phy_no_response = 1'b0;
                end
            end
        end
    end

    task automatic run_txn(input string tag, input bit is_auto, input logic [37:0] cmd,
                           input logic [31:0] arg, input att_t p[3]);
        int n_att, e_idle, e_ack, e_retry, e_tmo, e_lat;
        logic [135:0] e_resp;
        logic [37:0]  e_cmd;
        int strobes = 0, idles = 0, acks = 0, cyc = 0, first_s = -1, done_c = -1;
        bit done = 0;
        model(p, last_resp, n_att, e_idle, e_ack, e_retry, e_tmo, e_lat, e_resp);
        for (int i = 0; i < n_att; i++) plan_q.push_back(p[i]);
        bus.cmd_sw   = cmd;
        bus.arg_auto = arg;
        e_cmd = is_auto ? {6'd12, arg} : cmd;
        if (is_auto) bus.req_auto = 1'b1;
        else bus.req_sw = 1'b1;
        while (!done && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (bus.phy_strobe) begin
                strobes++;
                if (first_s < 0) first_s = cyc;
                check({tag, "_cmd"}, 136'(bus.phy_cmd), 136'(e_cmd));
                check({tag, "_gnt"}, 136'({bus.gnt_auto, bus.gnt_sw}), 136'(is_auto ? 2'b10 : 2'b01));
            end
            if (bus.phy_idle) idles++;
            if (bus.phy_ack) acks++;
            if (bus.done_sw || bus.done_auto) begin
                done = 1;
                done_c = cyc;
                check({tag, "_who"}, 136'({bus.done_auto, bus.done_sw}), 136'(is_auto ? 2'b10 : 2'b01));
                check({tag, "_resp"}, bus.resp, e_resp);
                check({tag, "_retry"}, 136'(bus.retry_cnt), 136'(e_retry));
                check({tag, "_tmo"}, 136'(bus.cmd_timeout), 136'(e_tmo));
                check({tag, "_cmd_held"}, 136'(bus.phy_cmd), 136'(e_cmd));
                bus.req_sw   = 1'b0;
                bus.req_auto = 1'b0;
            end
        end
        check({tag, "_done_seen"}, 136'(done), 136'(1));
        check({tag, "_strobes"}, 136'(strobes), 136'(n_att));
        check({tag, "_idles"}, 136'(idles), 136'(e_idle));
        check({tag, "_acks"}, 136'(acks), 136'(e_ack));
        check({tag, "_latency"}, 136'(done_c - first_s), 136'(e_lat));
        @(negedge clk);
        check({tag, "_done_1cyc"}, 136'({bus.done_auto, bus.done_sw, bus.gnt_auto, bus.gnt_sw}), 136'(0));
        last_resp = e_resp;
        @(negedge clk);
    endtask

    initial begin
        att_t p[3];
        int   cyc, ndone, nstr;
        bus.req_sw = 1'b0; bus.req_auto = 1'b0; bus.cmd_sw = '0; bus.arg_auto = '0;
        repeat (3) @(negedge clk);
        check("reset_outs", 136'({bus.gnt_sw, bus.gnt_auto, bus.done_sw, bus.done_auto,
              bus.phy_strobe, bus.phy_ack, bus.phy_idle, bus.cmd_timeout, bus.retry_cnt}), 136'(0));
        check("reset_cmd", 136'(bus.phy_cmd), 136'(0));
        check("reset_resp", bus.resp, 136'(0));
        rst_n = 1'b1;
        @(negedge clk);

        p = '{'{K_OK, 5, rnd136()}, '{K_SIL, 1, '0}, '{K_SIL, 1, '0}};
        run_txn("basic_sw", 0, {6'd17, 32'h0000_0200}, 32'h0, p);
        p = '{'{K_SIL, 1, '0}, '{K_SIL, 1, '0}, '{K_SIL, 1, '0}};
        run_txn("no_resp", 0, {6'd8, $urandom()}, 32'h0, p);
        p = '{'{K_SIL, 1, '0}, '{K_OK, 7, rnd136()}, '{K_SIL, 1, '0}};
        run_txn("retry_ok", 0, {6'd24, $urandom()}, 32'h0, p);
        p = '{'{K_NR, 3, rnd136()}, '{K_OK, 2, rnd136()}, '{K_SIL, 1, '0}};
        run_txn("no_resp_flag", 0, {6'd55, $urandom()}, 32'h0, p);
        p = '{'{K_OK, T, rnd136()}, '{K_SIL, 1, '0}, '{K_SIL, 1, '0}};
        run_txn("resp_at_limit", 1, {6'd3, $urandom()}, $urandom(), p);

        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 3; i++) begin
                p[i].kind = $urandom_range(0, 2);
                p[i].d    = (p[i].kind == K_SIL) ? 1 : $urandom_range(1, T);
                p[i].data = rnd136();
            end
            run_txn("rand", 1'($urandom_range(0, 1)), {6'($urandom_range(0, 63)), $urandom()}, $urandom(), p);
        end

        // Simultaneous requests: auto first, then the still-pending software command.
        plan_q.push_back('{K_OK, 2, rnd136()});
        plan_q.push_back('{K_OK, 4, rnd136()});
        bus.cmd_sw = {6'd17, 32'h1234_5678};
        bus.arg_auto = 32'hABCD_0001;
        bus.req_auto = 1'b1;
        bus.req_sw = 1'b1;
        cyc = 0; ndone = 0; nstr = 0;
        while (ndone < 2 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (bus.phy_strobe) begin
                nstr++;
                check("arb_cmd", 136'(bus.phy_cmd),
                      136'((nstr == 1) ? {6'd12, 32'hABCD_0001} : {6'd17, 32'h1234_5678}));
                check("arb_gnt", 136'({bus.gnt_auto, bus.gnt_sw}), 136'((nstr == 1) ? 2'b10 : 2'b01));
            end
            if (bus.done_sw || bus.done_auto) begin
                ndone++;
                check("arb_order", 136'({bus.done_auto, bus.done_sw}), 136'((ndone == 1) ? 2'b10 : 2'b01));
                if (bus.done_auto) bus.req_auto = 1'b0;
                if (bus.done_sw) bus.req_sw = 1'b0;
                last_resp = bus.resp;
            end
        end
        check("arb_dones", 136'(ndone), 136'(2));
        repeat (2) @(negedge clk);

        // Reset while waiting for a response that never comes.
        plan_q.delete();
        plan_q.push_back('{K_SIL, 1, '0});
        bus.cmd_sw = {6'd9, $urandom()};
        bus.req_sw = 1'b1;
        cyc = 0;
        while (!bus.phy_strobe && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_strobe_seen", 136'(bus.phy_strobe), 136'(1));
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", 136'({bus.gnt_sw, bus.gnt_auto, bus.done_sw, bus.done_auto,
              bus.phy_strobe, bus.phy_ack, bus.phy_idle, bus.cmd_timeout, bus.retry_cnt}), 136'(0));
        check("rst_mid_cmd", 136'(bus.phy_cmd), 136'(0));
        check("rst_mid_resp", bus.resp, 136'(0));
        repeat (3) @(negedge clk);
        check("rst_hold_pulses", 136'({bus.done_sw, bus.phy_ack, bus.phy_idle, bus.phy_strobe}), 136'(0));
        plan_q.delete();
        last_resp = '0;
        rst_n = 1'b1;
        p = '{'{K_OK, 4, rnd136()}, '{K_SIL, 1, '0}, '{K_SIL, 1, '0}};
        run_txn("after_rst", 0, {6'd9, $urandom()}, 32'h0, p);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
